// File: rtl/alu_multicycle.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_multicycle : 16-op ALU, registered result/flags, start/busy/done handshake.
//                  Define ALU_MUL_EN to build the iterative shift-add MUL.
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_multicycle #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  carry_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] product_hi,
   output logic                  zero_flag,
   output logic                  carry_flag,
   output logic                  negative_flag,
   output logic                  overflow_flag
);
   localparam int MSB = DATA_WIDTH - 1;

   localparam logic [OP_WIDTH-1:0] c_ADD = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] c_ADC = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] c_SUB = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] c_SBC = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] c_AND = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] c_OR  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] c_XOR = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] c_NOT = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] c_SHL = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] c_SHR = OP_WIDTH'(9);
   localparam logic [OP_WIDTH-1:0] c_ROL = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] c_ROR = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] c_CMP = OP_WIDTH'(12);
   localparam logic [OP_WIDTH-1:0] c_MUL = OP_WIDTH'(13);
   localparam logic [OP_WIDTH-1:0] c_INC = OP_WIDTH'(14);
   localparam logic [OP_WIDTH-1:0] c_DEC = OP_WIDTH'(15);

   logic [DATA_WIDTH-1:0] w_b_eff;
   logic                  w_cin;
   logic [DATA_WIDTH:0]   w_sum;
   logic                  w_add_v;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_c;
   logic                  w_v;
   logic                  w_wr_res;
   logic                  w_wr_flg;
   logic                  w_accept;
   logic                  w_mul_start;

   logic [DATA_WIDTH-1:0] result_d, result_q;
   logic                  z_d, z_q, c_d, c_q, n_d, n_q, v_d, v_q;
   logic                  done_d, done_q;

   // All add-type ops share one adder; only the effective B operand and carry differ.
   always_comb begin
      w_b_eff = b_in;
      w_cin   = 1'b0;
      case (op)
         c_ADC:        w_cin = carry_in;
         c_SUB, c_CMP: begin w_b_eff = ~b_in; w_cin = 1'b1;     end
         c_SBC:        begin w_b_eff = ~b_in; w_cin = carry_in; end
         c_INC:        begin w_b_eff = '0;    w_cin = 1'b1;     end
         c_DEC:        w_b_eff = '1;
         default:      ;
      endcase
   end

   assign w_sum   = {1'b0, a_in} + {1'b0, w_b_eff} + {{DATA_WIDTH{1'b0}}, w_cin};
   assign w_add_v = (a_in[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != a_in[MSB]);

   always_comb begin
      w_res    = w_sum[MSB:0];
      w_c      = w_sum[DATA_WIDTH];
      w_v      = w_add_v;
      w_wr_res = 1'b1;
      w_wr_flg = 1'b1;
      case (op)
         c_AND: begin w_res = a_in & b_in; w_c = 1'b0; w_v = 1'b0; end
         c_OR:  begin w_res = a_in | b_in; w_c = 1'b0; w_v = 1'b0; end
         c_XOR: begin w_res = a_in ^ b_in; w_c = 1'b0; w_v = 1'b0; end
         c_NOT: begin w_res = ~a_in;       w_c = 1'b0; w_v = 1'b0; end
         c_SHL: begin w_res = {a_in[MSB-1:0], 1'b0};     w_c = a_in[MSB]; w_v = 1'b0; end
         c_SHR: begin w_res = {1'b0, a_in[MSB:1]};       w_c = a_in[0];   w_v = 1'b0; end
         c_ROL: begin w_res = {a_in[MSB-1:0], carry_in}; w_c = a_in[MSB]; w_v = 1'b0; end
         c_ROR: begin w_res = {carry_in, a_in[MSB:1]};   w_c = a_in[0];   w_v = 1'b0; end
         c_CMP: w_wr_res = 1'b0;
         c_MUL: begin w_wr_res = 1'b0; w_wr_flg = 1'b0; end
         default: ;
      endcase
   end

   assign w_accept = start && !busy;

`ifdef ALU_MUL_EN
   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] c_LAST   = CW'(DATA_WIDTH - 1);
   localparam logic [0:0]    c_S_IDLE = 1'b0;
   localparam logic [0:0]    c_S_MUL  = 1'b1;

   logic [0:0]              state_d, state_q;
   logic [2*DATA_WIDTH-1:0] acc_d, acc_q, mcand_d, mcand_q, w_acc_step;
   logic [DATA_WIDTH-1:0]   mplier_d, mplier_q, phi_d, phi_q;
   logic [CW-1:0]           cnt_d, cnt_q;
   logic                    w_mul_last;

   assign busy        = (state_q == c_S_MUL);
   assign w_mul_start = w_accept && (op == c_MUL);
   assign w_mul_last  = busy && (cnt_q == c_LAST);
   assign w_acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign product_hi  = phi_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= c_S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         phi_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         phi_q    <= phi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_S_IDLE: if (w_mul_start) state_d = c_S_MUL;
         c_S_MUL:  if (w_mul_last)  state_d = c_S_IDLE;
         default:  state_d = c_S_IDLE;
      endcase
   end

   // One multiplier bit per cycle: shifted multiplicand added when the LSB is set.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (w_mul_start) begin
         acc_d    = '0;
         mcand_d  = {{DATA_WIDTH{1'b0}}, a_in};
         mplier_d = b_in;
         cnt_d    = '0;
      end else if (busy) begin
         acc_d    = w_acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end
`else
   assign busy        = 1'b0;
   assign w_mul_start = 1'b0;
   assign product_hi  = '0;
`endif

   always_comb begin
      result_d = result_q;
      z_d      = z_q;
      c_d      = c_q;
      n_d      = n_q;
      v_d      = v_q;
      done_d   = 1'b0;
      if (w_accept && !w_mul_start) begin
         done_d = 1'b1;
         if (w_wr_res) result_d = w_res;
         if (w_wr_flg) begin
            z_d = (w_res == '0);
            n_d = w_res[MSB];
            c_d = w_c;
            v_d = w_v;
         end
      end
`ifdef ALU_MUL_EN
      phi_d = phi_q;
      if (w_mul_last) begin
         done_d   = 1'b1;
         result_d = w_acc_step[DATA_WIDTH-1:0];
         phi_d    = w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
         z_d      = (w_acc_step[DATA_WIDTH-1:0] == '0);
         n_d      = w_acc_step[MSB];
         c_d      = |w_acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
         v_d      = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         n_q      <= 1'b0;
         v_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         z_q      <= z_d;
         c_q      <= c_d;
         n_q      <= n_d;
         v_q      <= v_d;
         done_q   <= done_d;
      end
   end

   assign done          = done_q;
   assign result        = result_q;
   assign zero_flag     = z_q;
   assign carry_flag    = c_q;
   assign negative_flag = n_q;
   assign overflow_flag = v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_multicycle : vector table, corner sequences and random ops checked
//                     against an arithmetic reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_alu_multicycle;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] op;
   logic [7:0] a_in, b_in;
   logic       carry_in;
   logic       busy, done;
   logic [7:0] result, product_hi;
   logic       zero_flag, carry_flag, negative_flag, overflow_flag;

   int n_checks = 0;
   int n_errors = 0;
   int m_res, m_phi, m_z, m_c, m_n, m_v;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_res;
      logic [3:0] exp_flags;   // {Z, C, N, V}
   } vec_t;

   vec_t vecs[15];

   alu_multicycle #(.DATA_WIDTH(8), .OP_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
      .busy(busy), .done(done), .result(result), .product_hi(product_hi),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .negative_flag(negative_flag), .overflow_flag(overflow_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] dut_flags();
      return {zero_flag, carry_flag, negative_flag, overflow_flag};
   endfunction

   function automatic int ovf(input int x);
      return (x > 127 || x < -128) ? 1 : 0;
   endfunction

   // Signed/unsigned integer arithmetic straight from the opcode definitions.
   function automatic void model(input int o, input int a, input int b, input int ci);
      int r, c, v, sa, sb;
`ifdef ALU_MUL_EN
      int p;
`endif
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      r = 0; c = 0; v = 0;
      case (o)
         0:  begin r = a + b;             v = ovf(sa + sb);          end
         1:  begin r = a + b + ci;        v = ovf(sa + sb + ci);     end
         2, 12: begin r = a + (255 - b) + 1;  v = ovf(sa - sb);      end
         3:  begin r = a + (255 - b) + ci; v = ovf(sa - sb - 1 + ci); end
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = 255 - a;
         8:  begin c = a >> 7; r = (a << 1) & 255;               end
         9:  begin c = a & 1;  r = a >> 1;                       end
         10: begin c = a >> 7; r = ((a << 1) & 255) | ci;        end
         11: begin c = a & 1;  r = (a >> 1) | (ci << 7);         end
         13: begin
`ifdef ALU_MUL_EN
            p     = a * b;
            m_res = p % 256;
            m_phi = p / 256;
            m_c   = (m_phi != 0) ? 1 : 0;
            m_v   = 0;
            m_z   = (m_res == 0) ? 1 : 0;
            m_n   = m_res / 128;
`endif
            return;
         end
         14: begin r = a + 1;   v = ovf(sa + 1); end
         default: begin r = a + 255; v = ovf(sa - 1); end
      endcase
      if (o < 4 || o == 12 || o >= 14) c = r / 256;
      r = r % 256;
      m_z = (r == 0) ? 1 : 0;
      m_n = r / 128;
      m_c = c;
      m_v = v;
      if (o != 12) m_res = r;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the completing edge with start low.
   task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic ci);
`ifdef ALU_MUL_EN
      int lat;
`endif
      op = o; a_in = a; b_in = b; carry_in = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 4'($urandom); a_in = 8'($urandom); b_in = 8'($urandom); carry_in = 1'($urandom);
`ifdef ALU_MUL_EN
      if (o == 4'hD) begin
         chk("mul_busy_after_start", busy, 1);
         lat = 0;
         while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         chk("mul_latency", lat, 8);
      end
`endif
      model(int'(o), int'(a), int'(b), int'(ci));
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_res"}, result, m_res);
      chk({tag, "_phi"}, product_hi, m_phi);
      chk({tag, "_flags"}, dut_flags(), m_z * 8 + m_c * 4 + m_n * 2 + m_v);
   endtask

   initial begin
      int bad;
`ifdef ALU_MUL_EN
      int lat;
`endif
      vecs[0]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
      vecs[1]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
      vecs[2]  = '{4'h2, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0010};
      vecs[3]  = '{4'hC, 8'h07, 8'h07, 1'b0, 8'hFE, 4'b1100};
      vecs[4]  = '{4'hB, 8'h01, 8'h00, 1'b1, 8'h80, 4'b0110};
      vecs[5]  = '{4'h3, 8'h10, 8'h01, 1'b0, 8'h0E, 4'b0100};
      vecs[6]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
      vecs[7]  = '{4'h5, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000};
      vecs[8]  = '{4'h7, 8'h55, 8'h00, 1'b0, 8'hAA, 4'b0010};
      vecs[9]  = '{4'h8, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0100};
      vecs[10] = '{4'h9, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0100};
      vecs[11] = '{4'hA, 8'h80, 8'h00, 1'b0, 8'h00, 4'b1100};
      vecs[12] = '{4'hF, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0010};
      vecs[13] = '{4'hE, 8'h7F, 8'h00, 1'b0, 8'h80, 4'b0011};
      vecs[14] = '{4'h1, 8'h7F, 8'h80, 1'b1, 8'h00, 4'b1100};

      reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; carry_in = 1'b0;
      m_res = 0; m_phi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_res", result, 0);
      chk("rst_phi", product_hi, 0);
      chk("rst_flags", dut_flags(), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
         chk($sformatf("vec%0d_done", i), done, 1);
         chk($sformatf("vec%0d_busy", i), busy, 0);
         chk($sformatf("vec%0d_res", i), result, vecs[i].exp_res);
         chk($sformatf("vec%0d_flags", i), dut_flags(), vecs[i].exp_flags);
      end

      run_op(4'h0, 8'h01, 8'h02, 1'b0);
      chk("b2b_add_done", done, 1);
      chk("b2b_add_res", result, 8'h03);
      run_op(4'h6, 8'hF0, 8'hFF, 1'b0);
      chk("b2b_xor_done", done, 1);
      chk("b2b_xor_res", result, 8'h0F);
      run_op(4'hE, 8'hFF, 8'h00, 1'b0);
      chk("b2b_inc_done", done, 1);
      chk("b2b_inc_res", result, 8'h00);
      chk("b2b_inc_flags", dut_flags(), 4'b1100);
      @(posedge clk); #1;
      chk("b2b_idle_done", done, 0);

`ifdef ALU_MUL_EN
      op = 4'hD; a_in = 8'h0F; b_in = 8'h11; carry_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("mul1_busy_e0", busy, 1);
      chk("mul1_done_e0", done, 0);
      lat = 0; bad = 0;
      while (!done && lat < 40) begin
         if (lat == 3) begin start = 1'b1; op = 4'h0; a_in = 8'h01; b_in = 8'h01; end
         else start = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (!done && !busy) bad++;
         if (done && busy) bad++;
      end
      start = 1'b0;
      model(13, 'h0F, 'h11, 0);
      chk("mul1_latency", lat, 8);
      chk("mul1_busy_done_overlap", bad, 0);
      chk("mul1_res", result, 8'hFF);
      chk("mul1_phi", product_hi, 8'h00);
      chk("mul1_carry", carry_flag, 0);
      cmp_model("mul1");
      @(posedge clk); #1;
      chk("mul1_ignored_start_done", done, 0);
      chk("mul1_ignored_start_res", result, 8'hFF);

      run_op(4'hD, 8'hFF, 8'hFF, 1'b0);
      chk("mul2_res", result, 8'h01);
      chk("mul2_phi", product_hi, 8'hFE);
      chk("mul2_carry", carry_flag, 1);
      cmp_model("mul2");
      run_op(4'h6, 8'h12, 8'h34, 1'b0);
      chk("phi_hold_after_xor", product_hi, 8'hFE);
`else
      run_op(4'hD, 8'h12, 8'h34, 1'b1);
      chk("nomul_d_res", result, 8'h00);
      chk("nomul_d_flags", dut_flags(), 4'b1100);
      cmp_model("nomul_d");
`endif

      for (int i = 0; i < 250; i++) begin
         run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         cmp_model($sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_idle_done", i), done, 0);
         end
      end

      run_op(4'h0, 8'hFF, 8'hFF, 1'b0);
      cmp_model("pre_reset_add");
`ifdef ALU_MUL_EN
      op = 4'hD; a_in = 8'hFF; b_in = 8'hFF; carry_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("abort_busy_before", busy, 1);
`endif
      #3 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_res", result, 0);
      chk("arst_phi", product_hi, 0);
      chk("arst_flags", dut_flags(), 0);
      m_res = 0; m_phi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) bad++;
      end
      chk("post_reset_quiet", bad, 0);
      run_op(4'h0, 8'h12, 8'h34, 1'b0);
      chk("post_reset_add_res", result, 8'h46);
      cmp_model("post_reset_add");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the datapath's 2-bit-opcode ALU.
- Provides 16 operations: add/sub with carry-in, logic, shifts/rotates, compare, increment/decrement, and an iterative shift-add multiply.
- Uses a start/busy/done handshake, so the control sequencer can stall on multi-cycle ops.
- Result and all four flags are registered, updated only on op completion, and held otherwise.

Parameters:
- DATA_WIDTH, 8, operand/result width (>=4).
- OP_WIDTH, 4, opcode width (fixed encoding below; must be 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge only when busy=0.
- op  input  OP_WIDTH  opcode, sampled with start.
- a_in  input  DATA_WIDTH  operand A, sampled with start.
- b_in  input  DATA_WIDTH  operand B, sampled with start.
- carry_in  input  1  carry for ADC/SBC/ROL/ROR, sampled with start.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse: result/flags just updated.
- result  output  DATA_WIDTH  registered result.
- product_hi  output  DATA_WIDTH  upper half of last MUL product.
- zero_flag, carry_flag, negative_flag, overflow_flag  output  1 each  registered flags.

Behaviour:
- Reset: state=IDLE; busy, done, result, product_hi and all flags = 0. An assertion mid-MUL aborts the op immediately; no done pulse follows.
- Opcodes:
  - 0 ADD, 1 ADC (a+b+carry_in), 2 SUB (a+~b+1), 3 SBC (a+~b+carry_in).
  - 4 AND, 5 OR, 6 XOR, 7 NOT (~a).
  - 8 SHL, 9 SHR (logical, 1 bit), A ROL, B ROR (1 bit, through carry_in).
  - C CMP, D MUL, E INC (a+1), F DEC (a+~0).
- Arithmetic is computed at DATA_WIDTH+1 bits; carry = bit DATA_WIDTH. For SUB/SBC/DEC/CMP, carry=1 means no borrow (A>=B unsigned).
- Overflow (add-type) = (a[MSB]==b'[MSB]) && (r[MSB]!=a[MSB]), where b' is the effective second operand.
- Logic ops: carry=0, overflow=0. Shifts/rotates: carry = bit shifted out, overflow=0.
- CMP: flags as SUB; result unchanged.
- zero/negative are derived from the value written to result (for CMP, from the SUB difference).
- State machine: IDLE, MUL_RUN.
  - IDLE, start=1, op!=MUL, at edge E0: result/flags written and done=1 for the following cycle; state stays IDLE; busy stays 0.
  - IDLE, start=1, op=MUL, at E0: latch operands, clear accumulator, iteration count=0, busy=1, go to MUL_RUN.
  - MUL_RUN: one multiplier bit per edge. At edge E(DATA_WIDTH): result=product[DATA_WIDTH-1:0], product_hi=product[2*DATA_WIDTH-1:DATA_WIDTH]; carry = |product_hi; overflow=0; zero/negative from the low half; done=1, busy=0; return to IDLE.
- MUL latency: exactly DATA_WIDTH cycles from E0 to done.
- start while busy=1 is ignored; no queueing.
- busy and done are never high together.
- A new start on the cycle done is high is accepted, back-to-back at 1 op/cycle for single-cycle ops.
- product_hi changes only on MUL completion.
- Inputs are don't-care except at the accepting edge.

Optional Feature:
- ALU_MUL_EN defined: MUL implemented as above.
- ALU_MUL_EN undefined: no MUL_RUN state or multiplier logic; product_hi ties to 0. Opcode D completes as a single-cycle op with done=1, result and flags unchanged, and busy never asserts.

Test Plan:
- ADD a=0xFF b=0x01 -> result=0x00, Z=1 C=1 N=0 V=0, done 1 cycle after start, busy stays 0.
- ADD a=0x7F b=0x01 -> 0x80, V=1 N=1 C=0. SUB a=0x05 b=0x07 -> 0xFE, C=0 N=1. CMP a=0x07 b=0x07 after them -> result holds 0xFE, Z=1 C=1.
- ROR a=0x01 carry_in=1 -> result=0x80, C=1. SBC a=0x10 b=0x01 carry_in=0 -> 0x0E, C=1.
- MUL a=0x0F b=0x11 (ALU_MUL_EN) -> busy high 8 cycles, done exactly 8 cycles after start, result=0xFF, product_hi=0x00, C=0. MUL 0xFF*0xFF -> 0x01, product_hi=0xFE, C=1. A start pulsed mid-MUL is ignored.
- Reset asserted 3 cycles into MUL -> busy/done/result/flags=0 asynchronously; no done afterward. The next ADD after release works normally.
- Back-to-back: starts on consecutive cycles ADD 1+2, XOR 0xF0^0xFF, INC 0xFF -> results 0x03, 0x0F, 0x00 (Z=1 C=1) on consecutive cycles, done high 3 cycles.
